// File: rtl/ldd_sched.sv
// ldd_sched: four-requester round-robin scheduler driving a shared ldd decoder.
// Each grant runs one ISSUE cycle, then HOLD cycles, then a one-cycle DONE pulse.
// Optional macro LDD_SCHED_AGE_EN adds per-requester 4-bit wait counters.
// A waiting requester whose count reaches AGE_MAX wins over the round-robin order.
//
// state | meaning
// IDLE  | waiting for any req; winner chosen and op/qual latched on exit
// ISSUE | dec_valid high for one cycle, gnt[winner] high
// HOLD  | decoder inputs and gnt held while cnt counts down to zero
// DONE  | done[winner] pulses for one cycle, last_winner updated
module ldd_sched #(
  parameter int HOLD_CYC = 2,
  parameter int AGE_MAX  = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] op,
  input  logic [3:0]  qual,
  output logic        dec_a,
  output logic        dec_b,
  output logic        dec_c,
  output logic        dec_i,
  output logic        dec_valid,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DONE} state_t;

  // Elaboration-time guard on the parameter ranges.
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("ldd_sched: HOLD_CYC must be 1..15");
  end
  if (AGE_MAX < 1 || AGE_MAX > 15) begin : g_bad_age
    $error("ldd_sched: AGE_MAX must be 1..15");
  end

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 2);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  win_idx;
  logic [1:0]  last_winner;
  logic [1:0]  sel_idx;
  logic [2:0]  op_sel;
  logic [3:0]  win_oh;

  // First requesting index strictly after last, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef LDD_SCHED_AGE_EN
  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

  logic [3:0] age_cnt [4];
  logic       aged_any;
  logic [1:0] aged_idx;

  // Lowest requesting index whose wait count has reached the limit.
  always_comb begin
    aged_any = 1'b0;
    aged_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k] && age_cnt[k] >= AGE_LIM) begin
        aged_any = 1'b1;
        aged_idx = 2'(k);
      end
    end
    sel_idx = aged_any ? aged_idx : rr_pick(req, last_winner);
  end

  // Wait counters: bump losers still requesting in DONE, clear on grant or idle-low req.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) age_cnt[k] <= 4'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (state == S_IDLE) begin
          if (!req[k] || sel_idx == 2'(k)) age_cnt[k] <= 4'd0;
        end else if (state == S_DONE) begin
          if (req[k] && win_idx != 2'(k) && age_cnt[k] != 4'hF)
            age_cnt[k] <= age_cnt[k] + 4'd1;
        end
      end
    end
  end
`else
  // Pure round-robin selection.
  always_comb sel_idx = rr_pick(req, last_winner);
`endif

  // Command field of the selected requester.
  always_comb begin
    op_sel = 3'b000;
    case (sel_idx)
      2'd0: op_sel = op[2:0];
      2'd1: op_sel = op[5:3];
      2'd2: op_sel = op[8:6];
      2'd3: op_sel = op[11:9];
      default: op_sel = 3'b000;
    endcase
  end

  // Next-state and hold-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (|req) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (HOLD_CYC == 1) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt == 4'd0) state_nxt = S_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, winner capture and decoder drive registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      win_idx     <= 2'd0;
      last_winner <= 2'd3;
      dec_a       <= 1'b0;
      dec_b       <= 1'b0;
      dec_c       <= 1'b0;
      dec_i       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && |req) begin
        win_idx               <= sel_idx;
        {dec_a, dec_b, dec_c} <= op_sel;
        dec_i                 <= qual[sel_idx];
      end
      if (state == S_DONE) last_winner <= win_idx;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    win_oh    = 4'b0001 << win_idx;
    dec_valid = (state == S_ISSUE);
    gnt       = (state == S_ISSUE || state == S_HOLD) ? win_oh : 4'b0000;
    done      = (state == S_DONE) ? win_oh : 4'b0000;
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_ldd_sched.sv
// Directed bench for ldd_sched: one instance with HOLD_CYC=2 (AGE_MAX=2 for the
// optional aging scenario) and one with HOLD_CYC=1. Inputs are driven and outputs
// sampled on the falling edge; "cycle 1" is the first cycle after the sampling edge.
module tb_ldd_sched;

  logic        clock;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] op;
  logic [3:0]  qual;

  logic        dec_a, dec_b, dec_c, dec_i, dec_valid, busy;
  logic [3:0]  gnt, done;
  logic        dec_a_1, dec_b_1, dec_c_1, dec_i_1, dec_valid_1, busy_1;
  logic [3:0]  gnt_1, done_1;

  int checks   = 0;
  int failures = 0;

  ldd_sched #(.HOLD_CYC(2), .AGE_MAX(2)) u_dut (
    .clock(clock), .rst_n(rst_n), .req(req), .op(op), .qual(qual),
    .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c), .dec_i(dec_i),
    .dec_valid(dec_valid), .gnt(gnt), .done(done), .busy(busy)
  );

  ldd_sched #(.HOLD_CYC(1), .AGE_MAX(8)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .req(req), .op(op), .qual(qual),
    .dec_a(dec_a_1), .dec_b(dec_b_1), .dec_c(dec_c_1), .dec_i(dec_i_1),
    .dec_valid(dec_valid_1), .gnt(gnt_1), .done(done_1), .busy(busy_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    op    = 12'h000;
    qual  = 4'b0000;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, dec_valid, gnt, done} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b dec_valid=%b gnt=%b done=%b, required all zero",
               busy, dec_valid, gnt, done);
    end
    checks++;
    if ({dec_a, dec_b, dec_c, dec_i} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_dec: got %b required 0000", {dec_a, dec_b, dec_c, dec_i});
    end
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0001; op = 12'b000_000_000_101; qual = 4'b0001;
    @(negedge clock); // cycle 1: ISSUE
    checks++;
    if ({dec_valid, gnt, dec_a, dec_b, dec_c, dec_i} !== 9'b1_0001_1011) begin
      failures++;
      $display("FAIL basic_issue: dec_valid=%b gnt=%b dec=%b, required 1 0001 1011",
               dec_valid, gnt, {dec_a, dec_b, dec_c, dec_i});
    end
    op = 12'h000; qual = 4'b0000; // late change must not reach the decoder
    @(negedge clock); // cycle 2: HOLD
    checks++;
    if ({dec_valid, gnt, dec_a, dec_b, dec_c, dec_i, done} !== 13'b0_0001_1011_0000) begin
      failures++;
      $display("FAIL basic_hold: dec_valid=%b gnt=%b dec=%b done=%b, required 0 0001 1011 0000",
               dec_valid, gnt, {dec_a, dec_b, dec_c, dec_i}, done);
    end
    @(negedge clock); // cycle 3: DONE
    checks++;
    if ({done, gnt, dec_a, dec_b, dec_c, dec_i} !== 12'b0001_0000_1011) begin
      failures++;
      $display("FAIL basic_done: done=%b gnt=%b dec=%b, required 0001 0000 1011",
               done, gnt, {dec_a, dec_b, dec_c, dec_i});
    end
    req = 4'b0000;
    @(negedge clock); // cycle 4: IDLE
    checks++;
    if ({busy, done, gnt} !== 9'b0) begin
      failures++;
      $display("FAIL basic_idle: busy=%b done=%b gnt=%b, required 0 0000 0000", busy, done, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [5];
    int         n_done;
    int         last_cyc;
    int         viol;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    n_done = 0; last_cyc = 0; viol = 0;
    do_reset();
    req = 4'b1111;
    for (int cyc = 1; cyc <= 40 && n_done < 5; cyc++) begin
      @(negedge clock);
      if ((gnt != 4'b0 && done != 4'b0) || !$onehot0(gnt) || !$onehot0(done)) viol++;
      if (done != 4'b0) begin
        checks++;
        if (done !== exp_order[n_done]) begin
          failures++;
          $display("FAIL rr_order[%0d]: done=%b required %b", n_done, done, exp_order[n_done]);
        end
        if (n_done > 0) begin
          checks++;
          if (cyc - last_cyc != 4) begin
            failures++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles required 4", n_done, cyc - last_cyc);
          end
        end else begin
          checks++;
          if (cyc != 3) begin
            failures++;
            $display("FAIL rr_first_done: cycle %0d required 3", cyc);
          end
        end
        last_cyc = cyc;
        n_done++;
      end
    end
    checks++;
    if (n_done != 5) begin
      failures++;
      $display("FAIL rr_timeout: saw %0d done pulses required 5", n_done);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL rr_onehot: %0d cycles with overlapping or multi-hot gnt/done, required 0", viol);
    end
    req = 4'b0000;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_drop_and_late_req();
    do_reset();
    req = 4'b0100; op = 12'b000_011_000_000; qual = 4'b0000;
    @(negedge clock); // cycle 1: ISSUE of index 2
    checks++;
    if ({gnt, dec_a, dec_b, dec_c, dec_i} !== 8'b0100_0110) begin
      failures++;
      $display("FAIL drop_issue: gnt=%b dec=%b required 0100 0110", gnt, {dec_a, dec_b, dec_c, dec_i});
    end
    req = 4'b0000;
    @(negedge clock); // cycle 2: HOLD, req already dropped
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL drop_hold: gnt=%b required 0100", gnt);
    end
    req = 4'b0001; // arrives while busy
    @(negedge clock); // cycle 3: DONE
    checks++;
    if (done !== 4'b0100) begin
      failures++;
      $display("FAIL drop_done: done=%b required 0100", done);
    end
    @(negedge clock); // cycle 4: IDLE, new request arbitrated here
    checks++;
    if ({busy, gnt} !== 5'b0) begin
      failures++;
      $display("FAIL late_idle: busy=%b gnt=%b required 0 0000", busy, gnt);
    end
    @(negedge clock); // cycle 5: ISSUE of index 0
    checks++;
    if ({dec_valid, gnt} !== 5'b1_0001) begin
      failures++;
      $display("FAIL late_issue: dec_valid=%b gnt=%b required 1 0001", dec_valid, gnt);
    end
    req = 4'b0000;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    @(negedge clock); // cycle 1: ISSUE of index 3
    @(negedge clock); // cycle 2: HOLD
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_hold: gnt=%b required 1000", gnt);
    end
    rst_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({gnt, busy, done} !== 9'b0) begin
      failures++;
      $display("FAIL rstmid_abort: gnt=%b busy=%b done=%b required 0000 0 0000", gnt, busy, done);
    end
    rst_n = 1'b1; req = 4'b0010;
    @(negedge clock);
    checks++;
    if ({done, gnt} !== 8'b0000_0010) begin
      failures++;
      $display("FAIL rstmid_after: done=%b gnt=%b required 0000 0010", done, gnt);
    end
    req = 4'b0000;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_hold_one();
    do_reset();
    req = 4'b0100;
    @(negedge clock); // cycle 1
    checks++;
    if ({dec_valid_1, gnt_1} !== 5'b1_0100) begin
      failures++;
      $display("FAIL hold1_issue: dec_valid=%b gnt=%b required 1 0100", dec_valid_1, gnt_1);
    end
    @(negedge clock); // cycle 2
    checks++;
    if ({done_1, gnt_1} !== 8'b0100_0000) begin
      failures++;
      $display("FAIL hold1_done: done=%b gnt=%b required 0100 0000", done_1, gnt_1);
    end
    req = 4'b0000;
    @(negedge clock); // cycle 3
    checks++;
    if (busy_1 !== 1'b0) begin
      failures++;
      $display("FAIL hold1_idle: busy=%b required 0", busy_1);
    end
    repeat (3) @(negedge clock);
  endtask

`ifdef LDD_SCHED_AGE_EN
  task automatic test_aging();
    do_reset();
    req = 4'b1011;
    @(negedge clock); // cycle 1: ISSUE index 0
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL age_first: gnt=%b required 0001", gnt);
    end
    repeat (4) @(negedge clock); // cycle 5: ISSUE index 1
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL age_second: gnt=%b required 0010", gnt);
    end
    repeat (3) @(negedge clock); // cycle 8: IDLE, index 3 has waited twice
    req = 4'b1111;
    @(negedge clock); // cycle 9: aged index 3 beats round-robin pick 2
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL age_force: gnt=%b required 1000", gnt);
    end
    req = 4'b0000;
    repeat (5) @(negedge clock);
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = 4'b0000; op = 12'h000; qual = 4'b0000;
    test_reset();
    test_basic();
    test_round_robin();
    test_drop_and_late_req();
    test_reset_mid();
    test_hold_one();
`ifdef LDD_SCHED_AGE_EN
    test_aging();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
